// File: rtl/mem_access_unit_if.sv
// Data RAM bus between the MEM-stage load/store unit (master) and the RAM (slave).
interface mem_access_unit_if;
    logic        ram_req;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_wstrb;
    logic [31:0] ram_rdata;
    logic        ram_ready;

    modport master (
        output ram_req, ram_we, ram_addr, ram_wdata, ram_wstrb,
        input  ram_rdata, ram_ready
    );

    modport slave (
        input  ram_req, ram_we, ram_addr, ram_wdata, ram_wstrb,
        output ram_rdata, ram_ready
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues one req/ready RAM transaction per load/store,
// formats store lanes, extends load data and reports misalignment and bus timeouts.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mem_valid,
    input  logic               memRead,
    input  logic               memWrite,
    input  logic [2:0]         funct3,
    input  logic [31:0]        mem_addr,
    input  logic [31:0]        mem_wdata,
    mem_access_unit_if.master  bus,
    output logic [31:0]        dataFromRAM,
    output logic               mem_stall,
    output logic               mem_done,
    output logic               access_fault,
    output logic               bus_error
);

    // Counter only has to reach TIMEOUT-1, the last WAIT cycle.
    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         wstrb_q, wstrb_d;
    logic [1:0]         off_q, off_d;
    logic [2:0]         f3_q, f3_d;
    logic [31:0]        data_q, data_d;
    logic               done_q, done_d;
    logic               fault_q, fault_d;
    logic               berr_q, berr_d;

    logic               start_c;
    logic               bad_c;
    logic [7:0]         byte_c;
    logic [15:0]        half_c;
    logic [31:0]        load_c;

    assign start_c = (state_q == S_IDLE) && mem_valid && (memRead || memWrite);

    // Width/alignment legality of the incoming access
    always_comb begin
        bad_c = 1'b1;
        case (funct3)
            3'b000, 3'b100: bad_c = 1'b0;
            3'b001, 3'b101: bad_c = mem_addr[0];
            3'b010:         bad_c = |mem_addr[1:0];
            default:        bad_c = 1'b1;
        endcase
    end

    // Lane extraction and extension of the returned read word
    always_comb begin
        byte_c = 8'(bus.ram_rdata >> {off_q, 3'b000});
        half_c = off_q[1] ? bus.ram_rdata[31:16] : bus.ram_rdata[15:0];
        case (f3_q)
            3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
            3'b100:  load_c = {24'd0, byte_c};
            3'b001:  load_c = {{16{half_c[15]}}, half_c};
            3'b101:  load_c = {16'd0, half_c};
            default: load_c = bus.ram_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        off_d   = off_q;
        f3_d    = f3_q;
        data_d  = data_q;
        done_d  = 1'b0;
        fault_d = 1'b0;
        berr_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_c && bad_c) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    fault_d = 1'b1;
                end else if (start_c) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = memWrite;
                    addr_d  = {mem_addr[31:2], 2'b00};
                    off_d   = mem_addr[1:0];
                    f3_d    = funct3;
                    if (!memWrite) begin
                        wdata_d = '0;
                        wstrb_d = 4'b1111;
                    end else begin
                        case (funct3[1:0])
                            2'b00: begin
                                wdata_d = {4{mem_wdata[7:0]}};
                                wstrb_d = 4'b0001 << mem_addr[1:0];
                            end
                            2'b01: begin
                                wdata_d = {2{mem_wdata[15:0]}};
                                wstrb_d = mem_addr[1] ? 4'b1100 : 4'b0011;
                            end
                            default: begin
                                wdata_d = mem_wdata;
                                wstrb_d = 4'b1111;
                            end
                        endcase
                    end
                end
            end
            S_WAIT: begin
                // Ready on the final allowed cycle still completes normally
                if (bus.ram_ready) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    if (!we_q) data_d = load_c;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    berr_d  = 1'b1;
                    if (!we_q) data_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            data_q  <= data_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            berr_q  <= berr_d;
        end
    end

    assign bus.ram_req   = req_q;
    assign bus.ram_we    = we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.ram_wstrb = wstrb_q;
    assign dataFromRAM   = data_q;
    assign mem_done      = done_q;
    assign access_fault  = fault_q;
    assign bus_error     = berr_q;
    assign mem_stall     = start_c || (state_q == S_WAIT);

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed loads/stores, faults, timeout, reset abort.
module tb_mem_access_unit;

    localparam int unsigned TO = 4;

    typedef struct packed {
        logic [31:0] data;
        logic        fault;
        logic        berr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid, memRead, memWrite;
    logic [2:0]  funct3;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] dataFromRAM;
    logic        mem_stall, mem_done, access_fault, bus_error;

    int tests = 0;
    int fails = 0;
    exp_t sb_q[$];

    mem_access_unit_if bus_if();

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_valid    (mem_valid),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .funct3       (funct3),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .bus          (bus_if),
        .dataFromRAM  (dataFromRAM),
        .mem_stall    (mem_stall),
        .mem_done     (mem_done),
        .access_fault (access_fault),
        .bus_error    (bus_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every completion pulse is matched against the oldest expected result
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_done === 1'b1) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got mem_done=1 expected no completion at %0t", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_data",  dataFromRAM, e.data);
                chk("sb_fault", 32'(access_fault), 32'(e.fault));
                chk("sb_berr",  32'(bus_error), 32'(e.berr));
            end
        end
    end

    // k = cycle after start in which ready is given; k=0 means ready never comes
    task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int k, input logic [31:0] rdat, input logic flt,
                         input logic [31:0] e_wdata, input logic [3:0] e_wstrb,
                         input logic [31:0] e_data);
        exp_t e;
        int   n;
        @(posedge clk); #1;
        mem_valid = 1'b1; memRead = rd; memWrite = wr;
        funct3 = f3; mem_addr = addr; mem_wdata = wd;
        bus_if.ram_ready = 1'b0;
        e.data  = e_data;
        e.fault = flt;
        e.berr  = !flt && (k == 0);
        sb_q.push_back(e);
        @(negedge clk);
        chk("stall_at_start", 32'(mem_stall), 32'd1);
        chk("req_low_at_start", 32'(bus_if.ram_req), 32'd0);
        @(posedge clk); #1;
        mem_valid = 1'b0; memRead = 1'b0; memWrite = 1'b0;
        if (flt) begin
            @(negedge clk);
            chk("fault_done", 32'(mem_done), 32'd1);
            chk("fault_no_req", 32'(bus_if.ram_req), 32'd0);
            chk("fault_no_stall", 32'(mem_stall), 32'd0);
            return;
        end
        n = (k == 0) ? int'(TO) : k;
        for (int j = 1; j <= n; j++) begin
            if (j == k) begin
                bus_if.ram_ready = 1'b1;
                bus_if.ram_rdata = rdat;
            end else begin
                bus_if.ram_rdata = 32'h5A5A_5A5A;
            end
            @(negedge clk);
            chk("wait_req", 32'(bus_if.ram_req), 32'd1);
            chk("wait_we", 32'(bus_if.ram_we), 32'(wr));
            chk("wait_addr", bus_if.ram_addr, {addr[31:2], 2'b00});
            chk("wait_wdata", bus_if.ram_wdata, e_wdata);
            chk("wait_wstrb", 32'(bus_if.ram_wstrb), 32'(e_wstrb));
            chk("wait_stall", 32'(mem_stall), 32'd1);
            chk("wait_no_done", 32'(mem_done), 32'd0);
            @(posedge clk); #1;
            bus_if.ram_ready = 1'b0;
        end
        @(negedge clk);
        chk("end_req_low", 32'(bus_if.ram_req), 32'd0);
        chk("end_done", 32'(mem_done), 32'd1);
        chk("end_no_stall", 32'(mem_stall), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},   32'(bus_if.ram_req), 32'd0);
        chk({tag, "_we"},    32'(bus_if.ram_we), 32'd0);
        chk({tag, "_addr"},  bus_if.ram_addr, 32'd0);
        chk({tag, "_wdata"}, bus_if.ram_wdata, 32'd0);
        chk({tag, "_wstrb"}, 32'(bus_if.ram_wstrb), 32'd0);
        chk({tag, "_data"},  dataFromRAM, 32'd0);
        chk({tag, "_done"},  32'(mem_done), 32'd0);
        chk({tag, "_fault"}, 32'(access_fault), 32'd0);
        chk({tag, "_berr"},  32'(bus_error), 32'd0);
        chk({tag, "_stall"}, 32'(mem_stall), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        mem_valid = 1'b0; memRead = 1'b0; memWrite = 1'b0;
        funct3 = 3'b000; mem_addr = '0; mem_wdata = '0;
        bus_if.ram_ready = 1'b0; bus_if.ram_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("reset");

        //    rd    wr    f3      addr           wdata          k  rdata          flt   e_wdata        strb     e_data
        do_op(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0,         2, 32'h80FF_0000, 1'b0, 32'h0,         4'b1111, 32'hFFFF_FF80);
        do_op(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0,         1, 32'hBEEF_1234, 1'b0, 32'h0,         4'b1111, 32'h0000_BEEF);
        do_op(1'b0, 1'b1, 3'b000, 32'h0000_3001, 32'h0000_00AB, 4, 32'h0,         1'b0, 32'hABAB_ABAB, 4'b0010, 32'h0000_BEEF);
        do_op(1'b1, 1'b0, 3'b010, 32'h0000_4002, 32'h0,         1, 32'h0,         1'b1, 32'h0,         4'b1111, 32'h0000_BEEF);
        do_op(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0,         0, 32'h0,         1'b0, 32'h0,         4'b1111, 32'h0000_0000);
        do_op(1'b1, 1'b0, 3'b010, 32'h0000_5004, 32'h0,         4, 32'hCAFE_F00D, 1'b0, 32'h0,         4'b1111, 32'hCAFE_F00D);
        do_op(1'b1, 1'b0, 3'b001, 32'h0000_6002, 32'h0,         1, 32'h8001_7FFF, 1'b0, 32'h0,         4'b1111, 32'hFFFF_8001);
        do_op(1'b0, 1'b1, 3'b001, 32'h0000_7002, 32'h1234_ABCD, 2, 32'h0,         1'b0, 32'hABCD_ABCD, 4'b1100, 32'hFFFF_8001);
        do_op(1'b1, 1'b0, 3'b100, 32'h0000_8001, 32'h0,         3, 32'h0000_F100, 1'b0, 32'h0,         4'b1111, 32'h0000_00F1);
        do_op(1'b1, 1'b0, 3'b011, 32'h0000_9000, 32'h0,         1, 32'h0,         1'b1, 32'h0,         4'b1111, 32'h0000_00F1);
        do_op(1'b0, 1'b1, 3'b001, 32'h0000_7001, 32'h0,         1, 32'h0,         1'b1, 32'h0,         4'b1111, 32'h0000_00F1);

        // mem_valid with no op and a stray ready: nothing must happen
        @(posedge clk); #1;
        mem_valid = 1'b1; bus_if.ram_ready = 1'b1; bus_if.ram_rdata = 32'h1111_1111;
        @(negedge clk);
        chk("novalid_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        mem_valid = 1'b0; bus_if.ram_ready = 1'b0;
        @(negedge clk);
        chk("novalid_req", 32'(bus_if.ram_req), 32'd0);
        chk("novalid_data", dataFromRAM, 32'h0000_00F1);

        // Read and write together: store wins
        do_op(1'b1, 1'b1, 3'b010, 32'h0000_A000, 32'h1122_3344, 1, 32'h9999_9999, 1'b0, 32'h1122_3344, 4'b1111, 32'h0000_00F1);

        // Reset while waiting on the bus
        @(posedge clk); #1;
        mem_valid = 1'b1; memRead = 1'b1; funct3 = 3'b010; mem_addr = 32'h0000_B000;
        @(posedge clk); #1;
        mem_valid = 1'b0; memRead = 1'b0;
        @(negedge clk);
        chk("rstwait_req", 32'(bus_if.ram_req), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("rstwait");
        @(negedge clk);
        chk("rstwait_idle_req", 32'(bus_if.ram_req), 32'd0);

        // Back-to-back stores; second op already presented during DONE
        do_op(1'b0, 1'b1, 3'b010, 32'h0000_C000, 32'hAAAA_5555, 1, 32'h0, 1'b0, 32'hAAAA_5555, 4'b1111, 32'h0);
        mem_valid = 1'b1; memWrite = 1'b1; funct3 = 3'b010; mem_addr = 32'h0000_C004; mem_wdata = 32'h0F0F_0F0F;
        do_op(1'b0, 1'b1, 3'b010, 32'h0000_C004, 32'h0F0F_0F0F, 1, 32'h0, 1'b0, 32'h0F0F_0F0F, 4'b1111, 32'h0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
